// File: rtl/integrator_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// integrator_arbiter_if : sample-lane and dump-port bundle for integrator_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface integrator_arbiter_if #(
  parameter int N = 16,
  parameter int M = 20,
  parameter int K = 4
) ();
  localparam int CW = $clog2(K);

  logic [K*N-1:0] in;
  logic [K-1:0]   in_valid;
  logic [K-1:0]   in_ready;
  logic [M-1:0]   out;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_ch, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_ch, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/integrator_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// integrator_arbiter : K-channel round-robin integrate-and-dump on one adder
// Rev 1.0
// ---------------------------------------------------------------------------
module integrator_arbiter #(
  parameter int N = 16,
  parameter int M = 20,
  parameter int K = 4,
  parameter int D = 8
) (
  input wire clk,
  input wire clr,
  integrator_arbiter_if.slave bus
);
  localparam int CW       = $clog2(K);
  localparam int CNTW     = $clog2(D);
  localparam int CNT_LAST = D - 1;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  logic signed [M-1:0] r_acc [K];
  logic [CNTW-1:0]     r_cnt [K];
  logic [CW-1:0]       r_rr;
  logic signed [M-1:0] r_out;
  logic [CW-1:0]       r_out_ch;
  slot_t               r_slot;
  slot_t               w_slot_nxt;

  logic                w_out_valid;
  logic                w_drain;
  logic [K-1:0]        w_elig;
  logic [CW-1:0]       w_gnt;
  logic                w_gnt_vld;
  int                  w_idx;
  logic                w_xfer;
  logic                w_last;
  logic                w_dump;
  logic signed [N-1:0] w_smp;
  logic signed [M-1:0] w_smp_ext;
  logic signed [M-1:0] w_sum;
  logic [CW-1:0]       w_rr_nxt;

  assign w_out_valid = (r_slot == SLOT_FULL);
  assign w_drain     = w_out_valid & bus.out_ready;

  // A channel on its last sample waits only while the slot is full and not draining.
  for (genvar i = 0; i < K; i++) begin : g_elig
    assign w_elig[i] = bus.in_valid[i] &
                       ~((r_cnt[i] == CNTW'(CNT_LAST)) & w_out_valid & ~bus.out_ready);
  end

  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_idx     = 0;
    for (int j = 0; j < K; j++) begin
      w_idx = int'(r_rr) + j;
      if (w_idx >= K) begin
        w_idx = w_idx - K;
      end
      if (!w_gnt_vld && w_elig[CW'(w_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CW'(w_idx);
      end
    end
  end

  assign w_xfer    = w_gnt_vld & ~clr;
  assign w_smp     = bus.in[w_gnt*N +: N];
  assign w_smp_ext = M'(w_smp);
  assign w_sum     = r_acc[w_gnt] + w_smp_ext;
  assign w_last    = (r_cnt[w_gnt] == CNTW'(CNT_LAST));
  assign w_dump    = w_xfer & w_last;
  assign w_rr_nxt  = (w_gnt == CW'(K - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    w_slot_nxt = r_slot;
    case (r_slot)
      SLOT_EMPTY: if (w_dump) w_slot_nxt = SLOT_FULL;
      SLOT_FULL:  if (!w_dump && w_drain) w_slot_nxt = SLOT_EMPTY;
      default:    w_slot_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < K; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_rr     <= '0;
      r_out    <= '0;
      r_out_ch <= '0;
      r_slot   <= SLOT_EMPTY;
    end else begin
      r_slot <= w_slot_nxt;
      if (w_xfer) begin
        r_rr <= w_rr_nxt;
        if (w_last) begin
          r_acc[w_gnt] <= '0;
          r_cnt[w_gnt] <= '0;
          r_out        <= w_sum;
          r_out_ch     <= w_gnt;
        end else begin
          r_acc[w_gnt] <= w_sum;
          r_cnt[w_gnt] <= r_cnt[w_gnt] + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_xfer ? (K'(1) << w_gnt) : '0;
  assign bus.out       = r_out;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = w_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_integrator_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_integrator_arbiter : self-checking bench, 20-bit and 17-bit accumulators
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_integrator_arbiter;
  localparam int N  = 16;
  localparam int M  = 20;
  localparam int M2 = 17;
  localparam int K  = 4;
  localparam int D  = 8;

  logic           clk;
  logic           clr;
  logic [K*N-1:0] in_v;
  logic [K-1:0]   inv;
  logic           ordy;

  integrator_arbiter_if #(.N(N), .M(M),  .K(K)) bus  ();
  integrator_arbiter_if #(.N(N), .M(M2), .K(K)) bus2 ();

  assign bus.in         = in_v;
  assign bus.in_valid   = inv;
  assign bus.out_ready  = ordy;
  assign bus2.in        = in_v;
  assign bus2.in_valid  = inv;
  assign bus2.out_ready = ordy;

  integrator_arbiter #(.N(N), .M(M),  .K(K), .D(D)) u_dut   (.clk(clk), .clr(clr), .bus(bus));
  integrator_arbiter #(.N(N), .M(M2), .K(K), .D(D)) u_dut17 (.clk(clk), .clr(clr), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: unbounded sums, wrapped to the output width only when compared.
  longint m_acc [K];
  int     m_cnt [K];
  int     m_rr;
  longint m_out;
  int     m_ch;
  bit     m_ov;
  bit     model_ok = 1'b0;
  int     m_g;

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint wrapw(longint v, int w);
    longint md = longint'(1) << w;
    longint r  = v % md;
    if (r < 0) r += md;
    if (r >= md / 2) r -= md;
    return r;
  endfunction

  function automatic int m_grant();
    int res = -1;
    for (int j = 0; j < K; j++) begin
      int c;
      c = (m_rr + j) % K;
      if (res < 0 && inv[c] && !(m_cnt[c] == D - 1 && m_ov && !ordy)) res = c;
    end
    return res;
  endfunction

  function automatic logic [K*N-1:0] bcast(int val);
    logic [N-1:0] t;
    t = N'(val);
    return {K{t}};
  endfunction

  task automatic drive(bit c, logic [K-1:0] v, logic [K*N-1:0] s, bit r);
    clr  = c;
    inv  = v;
    in_v = s;
    ordy = r;
  endtask

  task automatic settle_check();
    longint exp_rdy;
    #1;
    m_g = m_grant();
    if (model_ok) begin
      exp_rdy = (clr || m_g < 0) ? 0 : (longint'(1) << m_g);
      chk("in_ready",    longint'(bus.in_ready),  exp_rdy);
      chk("in_ready17",  longint'(bus2.in_ready), exp_rdy);
      chk("out_valid",   longint'(bus.out_valid), longint'(m_ov));
      chk("out_valid17", longint'(bus2.out_valid), longint'(m_ov));
      chk("out_ch",      longint'(bus.out_ch),    longint'(m_ch));
      chk("out",         longint'($signed(bus.out)),  wrapw(m_out, M));
      chk("out17",       longint'($signed(bus2.out)), wrapw(m_out, M2));
    end
  endtask

  task automatic clock_edge();
    bit     drain;
    bit     dump;
    longint s;
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < K; i++) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
      end
      m_rr = 0; m_out = 0; m_ch = 0; m_ov = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      drain = m_ov && ordy;
      dump  = 1'b0;
      if (m_g >= 0) begin
        s = longint'($signed(in_v[m_g*N +: N]));
        if (m_cnt[m_g] == D - 1) begin
          m_out = m_acc[m_g] + s;
          m_ch  = m_g;
          m_ov  = 1'b1;
          dump  = 1'b1;
          m_acc[m_g] = 0;
          m_cnt[m_g] = 0;
        end else begin
          m_acc[m_g] += s;
          m_cnt[m_g]++;
        end
        m_rr = (m_g + 1) % K;
      end
      if (!dump && drain) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, '0, '0, 1'b1);
    settle_check();
    clock_edge();
  endtask

  typedef struct {
    bit         c;
    bit [K-1:0] v;
    int         s;
    bit         r;
    bit [K-1:0] rdy;
    bit         ov;
    longint     out;
    int         ch;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 1000, 1'b1, 4'h0, 1'b0, 0,    0};
    tbl[1]  = '{1'b0, 4'hF, 1000, 1'b1, 4'h1, 1'b0, 0,    0};
    tbl[2]  = '{1'b1, 4'hF, 1000, 1'b1, 4'h0, 1'b0, 0,    0};
    for (int i = 3; i <= 10; i++) tbl[i] = '{1'b0, 4'h1, 1000, 1'b1, 4'h1, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 4'h0, 1000, 1'b1, 4'h0, 1'b1, 8000, 0};
    tbl[12] = '{1'b0, 4'h0, 1000, 1'b1, 4'h0, 1'b0, 8000, 0};

    // Reset held two cycles with all channels requesting, then single-channel block.
    drive(1'b1, 4'hF, bcast(1000), 1'b1);
    settle_check();
    chk("rst_in_ready",   longint'(bus.in_ready),  0);
    chk("rst_in_ready17", longint'(bus2.in_ready), 0);
    clock_edge();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].c, tbl[i].v, bcast(tbl[i].s), tbl[i].r);
      settle_check();
      chk("tbl_in_ready",  longint'(bus.in_ready),        longint'(tbl[i].rdy));
      chk("tbl_out_valid", longint'(bus.out_valid),       longint'(tbl[i].ov));
      chk("tbl_out",       longint'($signed(bus.out)),    tbl[i].out);
      chk("tbl_out_ch",    longint'(bus.out_ch),          longint'(tbl[i].ch));
      clock_edge();
    end

    // Sign extension and modular wrap on the 17-bit instance.
    do_reset();
    drive(1'b0, 4'h4, bcast(32767), 1'b1);
    for (int i = 0; i < 8; i++) begin settle_check(); clock_edge(); end
    drive(1'b0, 4'h0, bcast(0), 1'b1);
    settle_check();
    chk("wrap_pos_out",   longint'($signed(bus.out)),  262136);
    chk("wrap_pos_out17", longint'($signed(bus2.out)), -8);
    chk("wrap_pos_ch",    longint'(bus.out_ch),        2);
    clock_edge();
    drive(1'b0, 4'h4, bcast(-32768), 1'b1);
    for (int i = 0; i < 8; i++) begin settle_check(); clock_edge(); end
    drive(1'b0, 4'h0, bcast(0), 1'b1);
    settle_check();
    chk("wrap_neg_out",   longint'($signed(bus.out)),  -262144);
    chk("wrap_neg_out17", longint'($signed(bus2.out)), 0);
    clock_edge();

    // Fairness: four channels continuously valid with constants 1..4.
    do_reset();
    drive(1'b0, 4'hF, '0, 1'b1);
    for (int i = 0; i < K; i++) in_v[i*N +: N] = N'(i + 1);
    for (int c = 0; c < 34; c++) begin
      settle_check();
      chk("fair_grant", longint'(bus.in_ready), longint'(1) << (c % 4));
      if (c >= 29 && c <= 32) begin
        chk("fair_out",   longint'($signed(bus.out)), 8 * (c - 28));
        chk("fair_ch",    longint'(bus.out_ch),       c - 29);
        chk("fair_valid", longint'(bus.out_valid),    1);
      end
      clock_edge();
    end

    // Backpressure: ch1 on its last sample waits for the slot to drain.
    do_reset();
    drive(1'b0, 4'h1, bcast(50), 1'b0);
    for (int i = 0; i < 8; i++) begin settle_check(); clock_edge(); end
    drive(1'b0, 4'h2, bcast(50), 1'b0);
    for (int i = 0; i < 7; i++) begin settle_check(); clock_edge(); end
    drive(1'b0, 4'hE, bcast(50), 1'b0);
    for (int c = 0; c < 4; c++) begin
      settle_check();
      chk("bp_blocked",  longint'(bus.in_ready), (c % 2 == 0) ? 4 : 8);
      chk("bp_hold_out", longint'($signed(bus.out)), 400);
      clock_edge();
    end
    ordy = 1'b1;
    settle_check();
    chk("bp_release", longint'(bus.in_ready), 2);
    chk("bp_ch0",     longint'(bus.out_ch),   0);
    clock_edge();
    drive(1'b0, 4'h0, bcast(0), 1'b0);
    settle_check();
    chk("bp_ch1_valid", longint'(bus.out_valid), 1);
    chk("bp_ch1_ch",    longint'(bus.out_ch),    1);
    chk("bp_ch1_out",   longint'($signed(bus.out)), 400);
    clock_edge();

    // Mid-block reset discards partial sums and the sample presented with clr.
    do_reset();
    drive(1'b0, 4'h1, bcast(100), 1'b1);
    for (int i = 0; i < 5; i++) begin settle_check(); clock_edge(); end
    clr = 1'b1;
    settle_check();
    chk("mid_rst_ready", longint'(bus.in_ready), 0);
    clock_edge();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin settle_check(); clock_edge(); end
    inv = 4'h0;
    settle_check();
    chk("mid_rst_out",   longint'($signed(bus.out)), 800);
    chk("mid_rst_valid", longint'(bus.out_valid),    1);
    clock_edge();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clr  = ($urandom_range(0, 99) == 0);
      inv  = K'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < K; i++) begin
        case ($urandom_range(0, 7))
          0:       in_v[i*N +: N] = 16'h7FFF;
          1:       in_v[i*N +: N] = 16'h8000;
          default: in_v[i*N +: N] = N'($urandom);
        endcase
      end
      settle_check();
      clock_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
